// File: rtl/dircc_counter_send_handler.sv
// Counter send handler: services the lowest pending per-port send request,
// emits one packet per request and writes back the decremented rts / incremented count.
module dircc_counter_send_handler #(
  parameter int unsigned ADDRESS_MEM_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [31:0]                    rts_ready,
  input  logic [ADDRESS_MEM_WIDTH-1:0]   address,
  input  logic [31:0]                    user_state,
  input  logic                           running,
  output logic                           tx_valid,
  output logic [ADDRESS_MEM_WIDTH+31:0]  tx_data,
  input  logic                           tx_ready,
  output logic                           wr_en,
  output logic [31:0]                    wr_user_state,
  output logic                           busy,
  output logic [31:0]                    sent_total
);

  localparam int unsigned TX_W   = ADDRESS_MEM_WIDTH + 32;
  localparam int unsigned PORT_W = 5;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] WB   = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]        state_q,         state_d;
  logic              tx_valid_q,      tx_valid_d;
  logic [TX_W-1:0]   tx_data_q,       tx_data_d;
  logic              wr_en_q,         wr_en_d;
  logic [31:0]       wr_user_state_q, wr_user_state_d;
  logic              busy_q,          busy_d;
  logic [31:0]       sent_total_q,    sent_total_d;
  logic [31:0]       snap_state_q,    snap_state_d;

  logic [PORT_W-1:0] port_idx_c;
  logic              go_c;

  // Lowest set request bit wins; scan from the top so bit 0 is assigned last.
  always_comb begin
    port_idx_c = '0;
    for (int i = 31; i >= 0; i--) begin
      if (rts_ready[i]) port_idx_c = PORT_W'(i);
    end
  end

  assign go_c = (rts_ready != 32'd0) && running && (user_state[31:16] != 16'd0);

  always_comb begin
    state_d         = state_q;
    tx_valid_d      = tx_valid_q;
    tx_data_d       = tx_data_q;
    wr_en_d         = 1'b0;
    wr_user_state_d = wr_user_state_q;
    sent_total_d    = sent_total_q;
    snap_state_d    = snap_state_q;

    case (state_q)
      IDLE: begin
        if (go_c) begin
          state_d      = SEND;
          tx_valid_d   = 1'b1;
          tx_data_d    = {address, 8'(port_idx_c), 8'h00, user_state[15:0]};
          snap_state_d = user_state;
        end
      end
      SEND: begin
        // Packet is committed once valid; only acceptance releases it.
        if (tx_ready) begin
          state_d         = WB;
          tx_valid_d      = 1'b0;
          wr_en_d         = 1'b1;
          wr_user_state_d = {snap_state_q[31:16] - 16'd1, snap_state_q[15:0] + 16'd1};
          sent_total_d    = sent_total_q + 32'd1;
        end
      end
      WB: begin
        state_d = HOLD;
      end
      HOLD: begin
        // One dead cycle lets the upstream rts_ready register catch up.
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      tx_valid_q      <= 1'b0;
      tx_data_q       <= '0;
      wr_en_q         <= 1'b0;
      wr_user_state_q <= '0;
      busy_q          <= 1'b0;
      sent_total_q    <= '0;
      snap_state_q    <= '0;
    end else begin
      state_q         <= state_d;
      tx_valid_q      <= tx_valid_d;
      tx_data_q       <= tx_data_d;
      wr_en_q         <= wr_en_d;
      wr_user_state_q <= wr_user_state_d;
      busy_q          <= busy_d;
      sent_total_q    <= sent_total_d;
      snap_state_q    <= snap_state_d;
    end
  end

  assign tx_valid      = tx_valid_q;
  assign tx_data       = tx_data_q;
  assign wr_en         = wr_en_q;
  assign wr_user_state = wr_user_state_q;
  assign busy          = busy_q;
  assign sent_total    = sent_total_q;

endmodule

// File: tb/tb_dircc_counter_send_handler.sv
// Directed bench for dircc_counter_send_handler with a one-entry user_state memory model.
module tb_dircc_counter_send_handler;

  localparam int unsigned AW = 32;

  logic          clk;
  logic          reset_n;
  logic [31:0]   rts_ready;
  logic [AW-1:0] address;
  logic [31:0]   user_state;
  logic          running;
  logic          tx_valid;
  logic [AW+31:0] tx_data;
  logic          tx_ready;
  logic          wr_en;
  logic [31:0]   wr_user_state;
  logic          busy;
  logic [31:0]   sent_total;

  int n_checks = 0;
  int n_fail   = 0;

  dircc_counter_send_handler #(.ADDRESS_MEM_WIDTH(AW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rts_ready     (rts_ready),
    .address       (address),
    .user_state    (user_state),
    .running       (running),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .wr_en         (wr_en),
    .wr_user_state (wr_user_state),
    .busy          (busy),
    .sent_total    (sent_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle, sample 1ns after the edge; apply any write-back to the memory model.
  task automatic tick();
    @(posedge clk);
    #1;
    if (wr_en === 1'b1) user_state = wr_user_state;
  endtask

  logic [63:0] held;
  logic        prev_v;
  int          rises;
  int          rise_at[3];

  initial begin
    reset_n    = 1'b0;
    rts_ready  = '0;
    address    = 32'hA000_0010;
    user_state = '0;
    running    = 1'b0;
    tx_ready   = 1'b0;
    #23;
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_data", tx_data, 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_data", 64'(wr_user_state), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sent_total", 64'(sent_total), 64'd0);
    reset_n = 1'b1;
    tick();

    // Basic send
    user_state = 32'h0003_0005; running = 1'b1; tx_ready = 1'b1; rts_ready = 32'h1;
    tick();
    check("basic_valid", 64'(tx_valid), 64'd1);
    check("basic_data", tx_data, 64'hA000_0010_0000_0005);
    check("basic_busy", 64'(busy), 64'd1);
    rts_ready = '0;
    tick();
    check("basic_valid_drop", 64'(tx_valid), 64'd0);
    check("basic_wr_en", 64'(wr_en), 64'd1);
    check("basic_wr_data", 64'(wr_user_state), 64'h0002_0006);
    check("basic_sent", 64'(sent_total), 64'd1);
    tick();
    check("basic_hold_wr_en", 64'(wr_en), 64'd0);
    check("basic_hold_busy", 64'(busy), 64'd1);
    tick();
    check("basic_idle_busy", 64'(busy), 64'd0);

    // Backpressure: 5 stalled cycles, running dropped mid-hold
    user_state = 32'h0005_0010; tx_ready = 1'b0; rts_ready = 32'h1;
    tick();
    rts_ready = '0;
    held = 64'hA000_0010_0000_0010;
    for (int i = 0; i < 6; i++) begin
      check("bp_valid", 64'(tx_valid), 64'd1);
      check("bp_data", tx_data, held);
      check("bp_no_wr", 64'(wr_en), 64'd0);
      if (i == 2) running = 1'b0;
      if (i == 5) tx_ready = 1'b1;
      tick();
    end
    check("bp_valid_drop", 64'(tx_valid), 64'd0);
    check("bp_wr_en", 64'(wr_en), 64'd1);
    check("bp_wr_data", 64'(wr_user_state), 64'h0004_0011);
    check("bp_sent", 64'(sent_total), 64'd2);
    tick(); tick();
    check("bp_idle", 64'(busy), 64'd0);
    running = 1'b1;

    // Not running: request ignored
    user_state = 32'h0002_0000; running = 1'b0; rts_ready = 32'h1;
    tick(); tick();
    check("norun_valid", 64'(tx_valid), 64'd0);
    check("norun_busy", 64'(busy), 64'd0);
    running = 1'b1;

    // Count wrap, then rts==0 blocks further sends
    user_state = 32'h0001_FFFF; rts_ready = 32'h1;
    tick();
    check("wrap_data", tx_data, 64'hA000_0010_0000_FFFF);
    tick();
    check("wrap_wr_en", 64'(wr_en), 64'd1);
    check("wrap_wr_data", 64'(wr_user_state), 64'h0000_0000);
    tick(); tick(); tick(); tick();
    check("wrap_no_send", 64'(tx_valid), 64'd0);
    check("wrap_busy", 64'(busy), 64'd0);
    check("wrap_sent", 64'(sent_total), 64'd3);

    // Priority: lowest set bit of 0x14 is port 2
    address = 32'h1234_5678; user_state = 32'h0001_0007; rts_ready = 32'h0000_0014;
    tick();
    check("prio_data", tx_data, 64'h1234_5678_0200_0007);
    rts_ready = '0;
    tick();
    check("prio_wr_data", 64'(wr_user_state), 64'h0000_0008);
    tick(); tick();
    check("prio_sent", 64'(sent_total), 64'd4);

    // Throughput: rts=3 with request held yields three packets 4 cycles apart
    user_state = 32'h0003_0000; rts_ready = 32'h1;
    prev_v = 1'b0; rises = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (tx_valid && !prev_v) begin
        if (rises < 3) rise_at[rises] = c;
        rises++;
      end
      prev_v = tx_valid;
    end
    rts_ready = '0;
    check("tput_packets", 64'(rises), 64'd3);
    check("tput_gap1", 64'(rise_at[1] - rise_at[0]), 64'd4);
    check("tput_gap2", 64'(rise_at[2] - rise_at[1]), 64'd4);
    check("tput_sent", 64'(sent_total), 64'd7);
    check("tput_mem", 64'(user_state), 64'h0000_0003);
    check("tput_idle", 64'(busy), 64'd0);

    // Reset mid-SEND
    user_state = 32'h0002_0000; tx_ready = 1'b0; rts_ready = 32'h1;
    tick();
    check("rsend_valid", 64'(tx_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rsend_async_valid", 64'(tx_valid), 64'd0);
    check("rsend_async_data", tx_data, 64'd0);
    check("rsend_sent", 64'(sent_total), 64'd0);
    check("rsend_busy", 64'(busy), 64'd0);
    rts_ready = '0; tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rsend_no_wr", 64'(wr_en), 64'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rel_no_wr", 64'(wr_en), 64'd0);
      check("rel_no_valid", 64'(tx_valid), 64'd0);
    end
    check("rel_sent", 64'(sent_total), 64'd0);
    rts_ready = 32'h1;
    tick();
    check("rel_first_valid", 64'(tx_valid), 64'd1);
    rts_ready = '0;
    tick(); tick(); tick();
    check("rel_sent_after", 64'(sent_total), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
